// File: rtl/ula_mantissa_seq_if.sv
// Handshake and data bundle between a requester and the sequential mantissa ALU.
interface ula_mantissa_seq_if #(
   parameter int unsigned W = 24
) ();
   logic             start;
   logic [1:0]       op;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   dout;
   logic             c_out;
   logic             neg;

   modport master (
      output start, op, a, b,
      input  busy, done, dout, c_out, neg
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, dout, c_out, neg
   );
endinterface

// File: rtl/ula_mantissa_seq.sv
// Sequential mantissa ALU: single-cycle add/sub (magnitude + sign) with guard bits,
// and shift-and-add multiply, behind a start/done handshake.
module ula_mantissa_seq #(
   parameter int unsigned W          = 24,
   parameter int unsigned GUARD      = 3,
   parameter bit          EARLY_EXIT = 1'b0
) (
   input  logic                clk,
   input  logic                rst_n,
   ula_mantissa_seq_if.slave   bus
);

   localparam int unsigned W2 = 2 * W;
   localparam int unsigned CW = $clog2(W + 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [W-1:0]    mplr_q, mplr_d;
   logic [W2-1:0]   mcand_q, mcand_d;
   logic [W2-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [W2-1:0]   dout_q, dout_d;
   logic            c_out_q, c_out_d;
   logic            neg_q, neg_d;

   // Operand A lives in mplr_q and operand B in the low half of mcand_q during ADD.
   logic [W:0]      sum_w;
   logic [W-1:0]    diff_w;
   logic            a_lt_b;
   logic [W2-1:0]   acc_nxt;
   logic [W-1:0]    mplr_nxt;
   logic            mul_last;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      mplr_d   = mplr_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      dout_d   = dout_q;
      c_out_d  = c_out_q;
      neg_d    = neg_q;

      sum_w    = {1'b0, mplr_q} + {1'b0, mcand_q[W-1:0]};
      a_lt_b   = (mplr_q < mcand_q[W-1:0]);
      diff_w   = a_lt_b ? (mcand_q[W-1:0] - mplr_q) : (mplr_q - mcand_q[W-1:0]);
      acc_nxt  = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
      mplr_nxt = mplr_q >> 1;
      // Early exit looks at the multiplier after this cycle's shift.
      mul_last = (cnt_q == CW'(W - 1)) || (EARLY_EXIT && (mplr_nxt == '0));

      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d    = bus.op;
               mplr_d  = bus.a;
               mcand_d = W2'(bus.b);
               acc_d   = '0;
               cnt_d   = '0;
               state_d = (bus.op == OP_MUL) ? S_MUL : S_ADD;
            end
         end
         S_ADD: begin
            unique case (op_q)
               OP_ADD: begin
                  dout_d  = W2'(sum_w) << GUARD;
                  c_out_d = sum_w[W];
                  neg_d   = 1'b0;
               end
               OP_SUB: begin
                  dout_d  = W2'(diff_w) << GUARD;
                  c_out_d = 1'b0;
                  neg_d   = a_lt_b;
               end
               default: begin
                  dout_d  = '0;
                  c_out_d = 1'b0;
                  neg_d   = 1'b0;
               end
            endcase
            state_d = S_DONE;
         end
         S_MUL: begin
            acc_d   = acc_nxt;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_nxt;
            cnt_d   = cnt_q + CW'(1);
            if (mul_last) begin
               dout_d  = acc_nxt;
               c_out_d = acc_nxt[W2-1];
               neg_d   = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         mplr_q  <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         c_out_q <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mplr_q  <= mplr_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         c_out_q <= c_out_d;
         neg_q   <= neg_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.dout  = dout_q;
   assign bus.c_out = c_out_q;
   assign bus.neg   = neg_q;

endmodule

// File: tb/tb_ula_mantissa_seq.sv
// Scoreboard bench for ula_mantissa_seq: one full-run instance and one early-exit instance.
module tb_ula_mantissa_seq;

   localparam int unsigned W = 24;
   localparam int unsigned G = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   longint unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ula_mantissa_seq_if #(.W(W)) bus0 ();
   ula_mantissa_seq_if #(.W(W)) bus1 ();

   ula_mantissa_seq #(.W(W), .GUARD(G), .EARLY_EXIT(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   ula_mantissa_seq #(.W(W), .GUARD(G), .EARLY_EXIT(1'b1)) dut_ee (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      logic [47:0]     dout;
      logic            c;
      logic            n;
      longint unsigned cyc;
      string           tag;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                                  input bit ee, input longint unsigned k, input string tag);
      exp_t e;
      longint unsigned la = 64'(a);
      longint unsigned lb = 64'(b);
      longint unsigned r;
      int lat = 2;
      int nbits = 0;
      e.tag = tag;
      e.c = 1'b0;
      e.n = 1'b0;
      case (op)
         2'b00: begin
            r = la + lb;
            e.dout = 48'(r << G);
            e.c = ((r >> 24) & 64'd1) != 0;
         end
         2'b01: begin
            r = (la >= lb) ? la - lb : lb - la;
            e.dout = 48'(r << G);
            e.n = (la < lb);
         end
         2'b10: begin
            r = la * lb;
            e.dout = 48'(r);
            e.c = ((r >> 47) & 64'd1) != 0;
            if (ee) begin
               for (int i = 0; i < 24; i++) if (a[i]) nbits = i + 1;
               if (nbits == 0) nbits = 1;
               lat = nbits + 1;
            end else begin
               lat = W + 1;
            end
         end
         default: e.dout = '0;
      endcase
      e.cyc = k + 64'(lat);
      return e;
   endfunction

   function automatic logic busy_of(input int which);
      return (which == 0) ? bus0.busy : bus1.busy;
   endfunction

   task automatic drive(input int which, input logic s, input logic [1:0] op,
                        input logic [23:0] a, input logic [23:0] b);
      if (which == 0) begin
         bus0.start = s; bus0.op = op; bus0.a = a; bus0.b = b;
      end else begin
         bus1.start = s; bus1.op = op; bus1.a = a; bus1.b = b;
      end
   endtask

   task automatic issue(input int which, input logic [1:0] op, input logic [23:0] a,
                        input logic [23:0] b, input string tag);
      int   guard = 0;
      exp_t e;
      @(negedge clk);
      while (busy_of(which) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         total++; bad++;
         $display("FAIL %s: busy never dropped, waited %0d cycles", tag, guard);
      end
      drive(which, 1'b1, op, a, b);
      @(posedge clk);
      #1;
      e = model(op, a, b, which == 1, cyc, tag);
      if (which == 0) q0.push_back(e); else q1.push_back(e);
      chk({tag, "/busy_after_accept"}, 64'(busy_of(which)), 64'd1);
      // Scramble operands after acceptance; result must not care.
      drive(which, 1'b0, 2'($urandom), 24'($urandom), 24'($urandom));
   endtask

   function automatic logic [23:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 24'h000000;
         1: return 24'hFFFFFF;
         2: return 24'h800000 | 24'($urandom);
         default: return 24'($urandom);
      endcase
   endfunction

   // Monitors: pop expected entry on each done pulse.
   logic prev_done0 = 1'b0;
   logic prev_done1 = 1'b0;
   exp_t m0, m1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.done) begin
            if (prev_done0) begin
               total++; bad++;
               $display("FAIL dut/done_width: done high %0d consecutive cycles, expected 1", 2);
            end
            if (q0.size() == 0) begin
               total++; bad++;
               $display("FAIL dut/unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
               m0 = q0.pop_front();
               chk({m0.tag, "/dout"},  64'(bus0.dout),  64'(m0.dout));
               chk({m0.tag, "/c_out"}, 64'(bus0.c_out), 64'(m0.c));
               chk({m0.tag, "/neg"},   64'(bus0.neg),   64'(m0.n));
               chk({m0.tag, "/cycle"}, 64'(cyc),        64'(m0.cyc));
            end
         end
         if (bus1.done) begin
            if (prev_done1) begin
               total++; bad++;
               $display("FAIL dut_ee/done_width: done high %0d consecutive cycles, expected 1", 2);
            end
            if (q1.size() == 0) begin
               total++; bad++;
               $display("FAIL dut_ee/unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
               m1 = q1.pop_front();
               chk({m1.tag, "/dout"},  64'(bus1.dout),  64'(m1.dout));
               chk({m1.tag, "/c_out"}, 64'(bus1.c_out), 64'(m1.c));
               chk({m1.tag, "/neg"},   64'(bus1.neg),   64'(m1.n));
               chk({m1.tag, "/cycle"}, 64'(cyc),        64'(m1.cyc));
            end
         end
      end
      prev_done0 = rst_n && bus0.done;
      prev_done1 = rst_n && bus1.done;
   end

   initial begin
      int guard;
      drive(0, 1'b0, 2'b00, 24'h0, 24'h0);
      drive(1, 1'b0, 2'b00, 24'h0, 24'h0);
      repeat (3) @(negedge clk);
      chk("reset/busy",  64'(bus0.busy),  64'd0);
      chk("reset/done",  64'(bus0.done),  64'd0);
      chk("reset/dout",  64'(bus0.dout),  64'd0);
      chk("reset/c_out", 64'(bus0.c_out), 64'd0);
      chk("reset/neg",   64'(bus0.neg),   64'd0);
      #1 rst_n = 1'b1;

      issue(0, 2'b00, 24'hFFFFFF, 24'h000001, "add_carry");
      issue(0, 2'b01, 24'h000005, 24'h000009, "sub_neg");
      issue(0, 2'b01, 24'h000009, 24'h000005, "sub_pos");
      issue(0, 2'b11, 24'h123456, 24'h654321, "reserved");
      issue(0, 2'b10, 24'hFFFFFF, 24'hFFFFFF, "mul_max");
      issue(0, 2'b10, 24'h800000, 24'h800000, "mul_hidden");

      // Start pulse while busy must be ignored.
      issue(0, 2'b10, 24'hA5A5A5, 24'h5A5A5A, "mul_ignore");
      repeat (5) @(negedge clk);
      drive(0, 1'b1, 2'b00, 24'h111111, 24'h222222);
      @(negedge clk);
      drive(0, 1'b0, 2'b00, 24'h0, 24'h0);

      // Start held during the DONE cycle must be ignored.
      issue(0, 2'b00, 24'h000010, 24'h000020, "add_donecyc");
      @(negedge clk);
      @(negedge clk);
      drive(0, 1'b1, 2'b10, 24'h333333, 24'h444444);
      @(posedge clk);
      #1 drive(0, 1'b0, 2'b00, 24'h0, 24'h0);
      @(negedge clk);
      @(negedge clk);
      chk("donecyc_start/busy", 64'(bus0.busy), 64'd0);

      // Asynchronous reset in the middle of a multiply.
      issue(0, 2'b10, 24'hFFFFFF, 24'h00FFFF, "mul_reset");
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset/busy", 64'(bus0.busy), 64'd0);
      chk("midreset/done", 64'(bus0.done), 64'd0);
      chk("midreset/dout", 64'(bus0.dout), 64'd0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      issue(0, 2'b00, 24'h7FFFFF, 24'h000001, "add_after_reset");

      // Early-exit instance.
      issue(1, 2'b10, 24'h000001, 24'hABCDEF, "ee_mul_one");
      issue(1, 2'b10, 24'h000000, 24'hABCDEF, "ee_mul_zero");
      issue(1, 2'b10, 24'hFFFFFF, 24'hFFFFFF, "ee_mul_max");
      issue(1, 2'b01, 24'h000001, 24'hFFFFFF, "ee_sub");

      for (int i = 0; i < 30; i++)
         issue(0, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), $sformatf("rnd0_%0d", i));
      for (int i = 0; i < 20; i++)
         issue(1, 2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), $sformatf("rnd1_%0d", i));

      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0) && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      chk("drain/q0_left", 64'(q0.size()), 64'd0);
      chk("drain/q1_left", 64'(q1.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
